// File: rtl/hex_entry_editor.sv
// hex_entry_editor: five debounced buttons edit a 128-bit value one nibble at
// a time. It also reports the display window and the cursor position inside it,
// and it hands the committed value to a consumer over a valid/ready handshake.
module hex_entry_editor #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         btnL,
    input  logic         btnR,
    input  logic         btnU,
    input  logic         btnD,
    input  logic         btnC,
    input  logic         load_en,
    input  logic [127:0] load_data,
    output logic [127:0] data_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [4:0]   win_idx,
    output logic [1:0]   cursor_pos,
    output logic         editing
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    // Button bit positions inside the conditioned vectors
    localparam int B_L = 0;
    localparam int B_R = 1;
    localparam int B_U = 2;
    localparam int B_D = 3;
    localparam int B_C = 4;

    typedef enum logic [0:0] {
        ST_EDIT = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Step one nibble by +1/-1 with 4-bit wrap. Nibble 0 sits at the MSBs.
    function automatic logic [127:0] nib_step(input logic [127:0] v,
                                              input logic [4:0]   idx,
                                              input logic         up);
        logic [127:0] r;
        logic [3:0]   n;
        r = v;
        n = 4'd0;
        for (int i = 0; i < 32; i++) begin
            if (5'(i) == idx) begin
                n = v[127-4*i -: 4];
                r[127-4*i -: 4] = up ? (n + 4'd1) : (n - 4'd1);
            end
        end
        return r;
    endfunction

    // Slide the window so that it just covers the cursor. Move it as little as possible.
    function automatic logic [4:0] win_follow(input logic [4:0] cur,
                                              input logic [4:0] win);
        logic [4:0] r;
        if (cur < win) begin
            r = cur;
        end else if (cur > (win + 5'd3)) begin
            r = cur - 5'd3;
        end else begin
            r = win;
        end
        return r;
    endfunction

    logic [4:0]    raw_s;
    logic [4:0]    sync1_q;
    logic [4:0]    sync2_q;
    logic [4:0]    stable_q;
    logic [4:0]    stable_d;
    logic [4:0]    stable_prev_q;
    logic [4:0]    pulse_q;
    logic [CW-1:0] cnt_q [5];
    logic [CW-1:0] cnt_d [5];

    state_t        state_q;
    logic [127:0]  data_q;
    logic          valid_q;
    logic          editing_q;
    logic [4:0]    cursor_q;
    logic [4:0]    cursor_d;
    logic [4:0]    win_q;
    logic [4:0]    win_d;
    logic [1:0]    cpos_q;
    logic [1:0]    cpos_d;
    logic [4:0]    cpos_diff_s;

    assign raw_s = {btnC, btnD, btnU, btnR, btnL};

    // Two-flop synchronizer for the asynchronous button levels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 5'd0;
            sync2_q <= 5'd0;
        end else begin
            sync1_q <= raw_s;
            sync2_q <= sync1_q;
        end
    end

    // Debounce next state: count consecutive samples that differ from the stable level
    always_comb begin
        stable_d = stable_q;
        for (int b = 0; b < 5; b++) begin
            cnt_d[b] = cnt_q[b];
            if (sync2_q[b] != stable_q[b]) begin
                if (cnt_q[b] == CNT_LAST) begin
                    cnt_d[b]    = CNT_ZERO;
                    stable_d[b] = ~stable_q[b];
                end else begin
                    cnt_d[b] = cnt_q[b] + CNT_ONE;
                end
            end else begin
                cnt_d[b] = CNT_ZERO;
            end
        end
    end

    // Debounce state and press pulse generation. Only a stable 0->1 edge makes a pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_q      <= 5'd0;
            stable_prev_q <= 5'd0;
            pulse_q       <= 5'd0;
            for (int b = 0; b < 5; b++) begin
                cnt_q[b] <= CNT_ZERO;
            end
        end else begin
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            pulse_q       <= stable_q & ~stable_prev_q;
            for (int b = 0; b < 5; b++) begin
                cnt_q[b] <= cnt_d[b];
            end
        end
    end

    // Next cursor. Cursor moves only in EDIT, without load, and when no higher-priority commit is pending.
    always_comb begin
        cursor_d = cursor_q;
        if ((state_q == ST_EDIT) && !load_en && !pulse_q[B_C]) begin
            if (pulse_q[B_R]) begin
                if (cursor_q != 5'd31) begin
                    cursor_d = cursor_q + 5'd1;
                end else begin
                    cursor_d = cursor_q;
                end
            end else if (pulse_q[B_L]) begin
                if (cursor_q != 5'd0) begin
                    cursor_d = cursor_q - 5'd1;
                end else begin
                    cursor_d = cursor_q;
                end
            end else begin
                cursor_d = cursor_q;
            end
        end else begin
            cursor_d = cursor_q;
        end
        win_d       = win_follow(cursor_d, win_q);
        cpos_diff_s = cursor_d - win_d;
        cpos_d      = cpos_diff_s[1:0];
    end

    // Cursor, window and in-window offset registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cursor_q <= 5'd0;
            win_q    <= 5'd0;
            cpos_q   <= 2'd0;
        end else begin
            cursor_q <= cursor_d;
            win_q    <= win_d;
            cpos_q   <= cpos_d;
        end
    end

    // Edit/hold state machine: applies the value edits and runs the commit handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_EDIT;
            data_q    <= 128'd0;
            valid_q   <= 1'b0;
            editing_q <= 1'b1;
        end else begin
            case (state_q)
                ST_EDIT: begin
                    if (load_en) begin
                        data_q <= load_data;
                    end else if (pulse_q[B_C]) begin
                        valid_q   <= 1'b1;
                        editing_q <= 1'b0;
                        state_q   <= ST_HOLD;
                    end else if (pulse_q[B_R] || pulse_q[B_L]) begin
                        data_q <= data_q;
                    end else if (pulse_q[B_U]) begin
                        data_q <= nib_step(data_q, cursor_q, 1'b1);
                    end else if (pulse_q[B_D]) begin
                        data_q <= nib_step(data_q, cursor_q, 1'b0);
                    end else begin
                        data_q <= data_q;
                    end
                end
                ST_HOLD: begin
                    if (valid_q && out_ready) begin
                        valid_q   <= 1'b0;
                        editing_q <= 1'b1;
                        state_q   <= ST_EDIT;
                    end else begin
                        valid_q <= valid_q;
                    end
                end
                default: begin
                    state_q   <= ST_EDIT;
                    valid_q   <= 1'b0;
                    editing_q <= 1'b1;
                end
            endcase
        end
    end

    assign data_out   = data_q;
    assign out_valid  = valid_q;
    assign win_idx    = win_q;
    assign cursor_pos = cpos_q;
    assign editing    = editing_q;

endmodule

// File: tb/tb_hex_entry_editor.sv
// Testbench for hex_entry_editor (DEBOUNCE_CYCLES = 4). It applies table vectors,
// hand-timed sequences for the corner cases, and random presses. The random
// presses are checked against a nibble-array reference model.
module tb_hex_entry_editor;

    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic [4:0]   btn_raw;   // 0=L 1=R 2=U 3=D 4=C
    logic         load_en;
    logic [127:0] load_data;
    logic [127:0] data_out;
    logic         out_valid;
    logic         out_ready;
    logic [4:0]   win_idx;
    logic [1:0]   cursor_pos;
    logic         editing;

    int n_vec;
    int n_mis;

    // reference model state
    logic [3:0] m_nib [32];
    int         m_cur;
    int         m_win;
    bit         m_hold;

    hex_entry_editor #(.DEBOUNCE_CYCLES(N)) dut (
        .clk(clk), .rst(rst),
        .btnL(btn_raw[0]), .btnR(btn_raw[1]), .btnU(btn_raw[2]),
        .btnD(btn_raw[3]), .btnC(btn_raw[4]),
        .load_en(load_en), .load_data(load_data),
        .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
        .win_idx(win_idx), .cursor_pos(cursor_pos), .editing(editing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           btn;
        int           hold;
        logic [127:0] exp_data;
        logic [4:0]   exp_win;
        logic [1:0]   exp_pos;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] m_pack();
        logic [127:0] r;
        r = 128'd0;
        for (int i = 0; i < 32; i++) r[127-4*i -: 4] = m_nib[i];
        return r;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_nib[i] = 4'd0;
        m_cur = 0; m_win = 0; m_hold = 1'b0;
    endtask

    task automatic m_load(input logic [127:0] v);
        if (!m_hold) begin
            for (int i = 0; i < 32; i++) m_nib[i] = v[127-4*i -: 4];
        end
    endtask

    task automatic model_btn(input int code);
        if (!m_hold) begin
            case (code)
                0: if (m_cur > 0) m_cur = m_cur - 1;
                1: if (m_cur < 31) m_cur = m_cur + 1;
                2: m_nib[m_cur] = m_nib[m_cur] + 4'd1;
                3: m_nib[m_cur] = m_nib[m_cur] - 4'd1;
                4: m_hold = !out_ready;   // ready already high: transfer completes during settle
                default: ;
            endcase
            if (m_cur < m_win) m_win = m_cur;
            else if (m_cur > m_win + 3) m_win = m_cur - 3;
        end
    endtask

    task automatic check_all(input string name);
        chk({name, ".data"}, data_out, m_pack());
        chk({name, ".win"}, {123'd0, win_idx}, 128'(m_win));
        chk({name, ".pos"}, {126'd0, cursor_pos}, 128'(m_cur - m_win));
        chk({name, ".valid"}, {127'd0, out_valid}, {127'd0, m_hold});
        chk({name, ".editing"}, {127'd0, editing}, {127'd0, !m_hold});
    endtask

    // raw press of `hold` cycles, then a release long enough to settle; updates the model
    task automatic press(input int code, input int hold);
        btn_raw[code] = 1'b1;
        repeat (hold) @(negedge clk);
        btn_raw[code] = 1'b0;
        repeat (N + 6) @(negedge clk);
        if (hold >= N) model_btn(code);
    endtask

    task automatic do_load(input logic [127:0] v);
        load_data = v;
        load_en   = 1'b1;
        @(negedge clk);
        load_en   = 1'b0;
        m_load(v);
    endtask

    initial begin
        logic [127:0] rv;
        int code;
        n_vec = 0; n_mis = 0;
        btn_raw = 5'd0; load_en = 1'b0; load_data = 128'd0; out_ready = 1'b0;
        m_reset();

        tbl[0]  = '{2, 20, 128'h2000_0000_0000_0000_0000_0000_0000_0000, 5'd0, 2'd0};
        tbl[1]  = '{2, 3,  128'h2000_0000_0000_0000_0000_0000_0000_0000, 5'd0, 2'd0};
        tbl[2]  = '{3, 6,  128'h1000_0000_0000_0000_0000_0000_0000_0000, 5'd0, 2'd0};
        tbl[3]  = '{3, 6,  128'h0000_0000_0000_0000_0000_0000_0000_0000, 5'd0, 2'd0};
        tbl[4]  = '{3, 6,  128'hF000_0000_0000_0000_0000_0000_0000_0000, 5'd0, 2'd0};
        tbl[5]  = '{2, 6,  128'h0000_0000_0000_0000_0000_0000_0000_0000, 5'd0, 2'd0};
        tbl[6]  = '{1, 6,  128'h0000_0000_0000_0000_0000_0000_0000_0000, 5'd0, 2'd1};
        tbl[7]  = '{2, 6,  128'h0100_0000_0000_0000_0000_0000_0000_0000, 5'd0, 2'd1};
        tbl[8]  = '{0, 6,  128'h0100_0000_0000_0000_0000_0000_0000_0000, 5'd0, 2'd0};
        tbl[9]  = '{0, 6,  128'h0100_0000_0000_0000_0000_0000_0000_0000, 5'd0, 2'd0};
        tbl[10] = '{1, 2,  128'h0100_0000_0000_0000_0000_0000_0000_0000, 5'd0, 2'd0};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all("reset");
        rst = 1'b0;
        @(negedge clk);

        // held btnU: the press pulse lands after edge 7, so the edit appears after edge 8
        btn_raw[2] = 1'b1;
        repeat (7) @(negedge clk);
        chk("u_timing.before", data_out, 128'd0);
        @(negedge clk);
        chk("u_timing.after", data_out, 128'h1000_0000_0000_0000_0000_0000_0000_0000);
        repeat (12) @(negedge clk);
        btn_raw[2] = 1'b0;
        repeat (N + 6) @(negedge clk);
        model_btn(2);
        check_all("u_hold_once");

        for (int i = 0; i < 11; i++) begin
            press(tbl[i].btn, tbl[i].hold);
            chk($sformatf("tbl%0d.data", i), data_out, tbl[i].exp_data);
            chk($sformatf("tbl%0d.win", i), {123'd0, win_idx}, {123'd0, tbl[i].exp_win});
            chk($sformatf("tbl%0d.pos", i), {126'd0, cursor_pos}, {126'd0, tbl[i].exp_pos});
        end

        for (int i = 0; i < 34; i++) press(1, 5);
        chk("r_sat.win", {123'd0, win_idx}, 128'd28);
        chk("r_sat.pos", {126'd0, cursor_pos}, 128'd3);
        press(3, 5);
        chk("d_last", data_out, 128'h0100_0000_0000_0000_0000_0000_0000_000F);
        for (int i = 0; i < 5; i++) press(0, 5);
        chk("l5.win", {123'd0, win_idx}, 128'd26);
        chk("l5.pos", {126'd0, cursor_pos}, 128'd0);
        check_all("l5.model");

        // random presses, including short glitches and preloads
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                rv = {$urandom, $urandom, $urandom, $urandom};
                do_load(rv);
            end else begin
                code = $urandom_range(0, 3);
                press(code, $urandom_range(1, 8));
            end
            check_all($sformatf("rand%0d", k));
        end

        // commit with out_ready low: HOLD ignores buttons and load
        do_load(128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF);
        press(4, 6);
        check_all("commit.hold");
        repeat (10) @(negedge clk);
        press(2, 6);
        do_load(128'd5);
        check_all("commit.ignored");
        chk("commit.data", data_out, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF);
        out_ready = 1'b1;
        @(negedge clk);
        m_hold = 1'b0;
        out_ready = 1'b0;
        check_all("commit.release");

        // out_ready already high: HOLD lasts exactly one cycle
        out_ready = 1'b1;
        btn_raw[4] = 1'b1;
        repeat (8) @(negedge clk);
        chk("hold1.valid_up", {127'd0, out_valid}, 128'd1);
        @(negedge clk);
        chk("hold1.valid_down", {127'd0, out_valid}, 128'd0);
        chk("hold1.editing", {127'd0, editing}, 128'd1);
        btn_raw[4] = 1'b0;
        repeat (N + 6) @(negedge clk);
        out_ready = 1'b0;
        check_all("hold1.model");

        // simultaneous C and R: only the commit acts
        btn_raw[4] = 1'b1; btn_raw[1] = 1'b1;
        repeat (6) @(negedge clk);
        btn_raw[4] = 1'b0; btn_raw[1] = 1'b0;
        repeat (N + 6) @(negedge clk);
        model_btn(4);
        check_all("c_and_r");
        out_ready = 1'b1;
        @(negedge clk);
        m_hold = 1'b0;
        out_ready = 1'b0;
        check_all("c_and_r.release");

        // load_en in the same cycle as a btnU pulse: the load wins
        rv = {$urandom, $urandom, $urandom, $urandom};
        btn_raw[2] = 1'b1;
        repeat (7) @(negedge clk);
        load_data = rv; load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
        chk("load_vs_u", data_out, rv);
        repeat (2) @(negedge clk);
        btn_raw[2] = 1'b0;
        repeat (N + 6) @(negedge clk);
        m_load(rv);
        check_all("load_vs_u.model");

        // async reset while in HOLD with cursor 10
        do_load(128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555);
        for (int i = 0; i < 31; i++) press(0, 5);
        for (int i = 0; i < 10; i++) press(1, 5);
        press(4, 6);
        check_all("pre_reset");
        btn_raw[2] = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("arst.valid", {127'd0, out_valid}, 128'd0);
        chk("arst.data", data_out, 128'd0);
        chk("arst.win", {123'd0, win_idx}, 128'd0);
        chk("arst.pos", {126'd0, cursor_pos}, 128'd0);
        chk("arst.editing", {127'd0, editing}, 128'd1);
        m_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // btnU held through reset release re-qualifies as exactly one press
        repeat (7) @(negedge clk);
        chk("held_rst.before", data_out, 128'd0);
        @(negedge clk);
        chk("held_rst.after", data_out, 128'h1000_0000_0000_0000_0000_0000_0000_0000);
        repeat (12) @(negedge clk);
        btn_raw[2] = 1'b0;
        repeat (N + 6) @(negedge clk);
        model_btn(2);
        check_all("held_rst.once");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
